// File: rtl/axis_fifo_pause_ctrl.sv
// axis_fifo_pause_ctrl
//   Output-side flow controller for the AXIS FIFO adapter pause/status
//   interface. Holds the FIFO output (pause_req) until enough data is
//   buffered, so that downstream streaming sinks do not underrun mid-frame.
//   Releases on a fill threshold or, optionally, on a committed frame.
//   Re-pauses when the FIFO drains or software forces a hold. Also keeps
//   saturating event counters and a sticky pause-handshake timeout flag.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   status_depth          : current FIFO fill (words)
//   status_depth_commit   : committed (complete-frame) fill
//   status_overflow       : overflow event pulse
//   status_bad_frame      : bad-frame event pulse
//   status_good_frame     : good-frame event pulse
//   pause_req             : pause request to the FIFO output side
//   pause_ack             : FIFO reports its output is paused
//   force_pause           : software hold, overrides release
//   cnt_clear             : clears event counters and ack_timeout
//   paused                : registered pause_req & pause_ack
//   ack_timeout           : sticky, pause_req left unacknowledged too long
//   good_frame_count      : saturating good-frame count
//   bad_frame_count       : saturating bad-frame count
//   overflow_count        : saturating overflow count
//
// All outputs come straight from flops; there is no combinational path
// from any input to any output.

module axis_fifo_pause_ctrl #(
  parameter int unsigned DEPTH          = 4096,
  parameter int unsigned DW             = $clog2(DEPTH) + 1,
  parameter int unsigned START_LEVEL    = 1024,
  parameter bit          COMMIT_RELEASE = 1'b1,
  parameter int unsigned ACK_TIMEOUT    = 1024,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DW-1:0]        status_depth,
  input  logic [DW-1:0]        status_depth_commit,
  input  logic                 status_overflow,
  input  logic                 status_bad_frame,
  input  logic                 status_good_frame,
  output logic                 pause_req,
  input  logic                 pause_ack,
  input  logic                 force_pause,
  input  logic                 cnt_clear,
  output logic                 paused,
  output logic                 ack_timeout,
  output logic [CNT_WIDTH-1:0] good_frame_count,
  output logic [CNT_WIDTH-1:0] bad_frame_count,
  output logic [CNT_WIDTH-1:0] overflow_count
);

  // Timeout counter only needs to reach ACK_TIMEOUT; keep it at least 1 bit
  // so a disabled check (ACK_TIMEOUT == 0) still elaborates.
  localparam int unsigned   TW        = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX    = (ACK_TIMEOUT == 0) ? '0 : TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST   = (ACK_TIMEOUT == 0) ? '0 : TW'(ACK_TIMEOUT - 1);
  localparam logic [DW-1:0] START_LVL = DW'(START_LEVEL);

  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } state_e;

  state_e               state_q, state_d;
  logic                 pause_req_q, pause_req_d;
  logic                 paused_q, paused_d;
  logic                 ack_timeout_q, ack_timeout_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic                 to_hit;
  logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  logic release_ok;
  logic drain;

  // ---------------------------------------------------------------------
  // Release / drain conditions
  // ---------------------------------------------------------------------
  always_comb begin
    release_ok = 1'b0;
    if (!force_pause) begin
      if (status_depth >= START_LVL) begin
        release_ok = 1'b1;
      end
      if (COMMIT_RELEASE && (status_depth_commit != '0)) begin
        release_ok = 1'b1;
      end
    end
    drain = force_pause || (status_depth == '0);
  end

  // ---------------------------------------------------------------------
  // State machine: next state and registered pause_req
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: begin
        if (release_ok) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (drain) begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_HOLD;
    endcase
    // pause_req is registered from the next state so it tracks the FSM
    // with exactly one cycle of latency from the deciding inputs.
    pause_req_d = (state_d == ST_HOLD);
  end

  // ---------------------------------------------------------------------
  // Pause handshake status and ack timeout
  // ---------------------------------------------------------------------
  always_comb begin
    paused_d = pause_req_q && pause_ack;

    to_cnt_d = '0;
    to_hit   = 1'b0;
    if (pause_req_q && !pause_ack) begin
      if ((ACK_TIMEOUT != 0) && (to_cnt_q != TO_MAX)) begin
        to_cnt_d = to_cnt_q + TW'(1);
      end else begin
        to_cnt_d = to_cnt_q;
      end
      // Flag on the increment that reaches ACK_TIMEOUT only, so a saturated
      // counter does not immediately re-raise the flag after cnt_clear.
      to_hit = (ACK_TIMEOUT != 0) && (to_cnt_q == TO_LAST);
    end

    // A timeout reached in the clearing cycle wins over cnt_clear.
    ack_timeout_d = (ack_timeout_q && !cnt_clear) || to_hit;
  end

  // ---------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------
  // Clear is applied first and the pulse second, so a pulse coincident
  // with cnt_clear lands as a count of one.
  always_comb begin
    good_cnt_d = cnt_clear ? '0 : good_cnt_q;
    if (status_good_frame && (good_cnt_d != '1)) begin
      good_cnt_d = good_cnt_d + CNT_WIDTH'(1);
    end

    bad_cnt_d = cnt_clear ? '0 : bad_cnt_q;
    if (status_bad_frame && (bad_cnt_d != '1)) begin
      bad_cnt_d = bad_cnt_d + CNT_WIDTH'(1);
    end

    ovf_cnt_d = cnt_clear ? '0 : ovf_cnt_q;
    if (status_overflow && (ovf_cnt_d != '1)) begin
      ovf_cnt_d = ovf_cnt_d + CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HOLD;
      pause_req_q   <= 1'b1;
      paused_q      <= 1'b0;
      ack_timeout_q <= 1'b0;
      to_cnt_q      <= '0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      ovf_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      pause_req_q   <= pause_req_d;
      paused_q      <= paused_d;
      ack_timeout_q <= ack_timeout_d;
      to_cnt_q      <= to_cnt_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      ovf_cnt_q     <= ovf_cnt_d;
    end
  end

  assign pause_req        = pause_req_q;
  assign paused           = paused_q;
  assign ack_timeout      = ack_timeout_q;
  assign good_frame_count = good_cnt_q;
  assign bad_frame_count  = bad_cnt_q;
  assign overflow_count   = ovf_cnt_q;

endmodule

// File: tb/tb_axis_fifo_pause_ctrl.sv
// Directed testbench for axis_fifo_pause_ctrl with START_LEVEL = 1024,
// COMMIT_RELEASE = 1, ACK_TIMEOUT = 8, CNT_WIDTH = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge just taken.

module tb_axis_fifo_pause_ctrl;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned DW    = $clog2(DEPTH) + 1;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] status_depth;
  logic [DW-1:0] status_depth_commit;
  logic          status_overflow;
  logic          status_bad_frame;
  logic          status_good_frame;
  logic          pause_req;
  logic          pause_ack;
  logic          force_pause;
  logic          cnt_clear;
  logic          paused;
  logic          ack_timeout;
  logic [CW-1:0] good_frame_count;
  logic [CW-1:0] bad_frame_count;
  logic [CW-1:0] overflow_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  axis_fifo_pause_ctrl #(
    .DEPTH          (DEPTH),
    .START_LEVEL    (1024),
    .COMMIT_RELEASE (1'b1),
    .ACK_TIMEOUT    (8),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .status_depth        (status_depth),
    .status_depth_commit (status_depth_commit),
    .status_overflow     (status_overflow),
    .status_bad_frame    (status_bad_frame),
    .status_good_frame   (status_good_frame),
    .pause_req           (pause_req),
    .pause_ack           (pause_ack),
    .force_pause         (force_pause),
    .cnt_clear           (cnt_clear),
    .paused              (paused),
    .ack_timeout         (ack_timeout),
    .good_frame_count    (good_frame_count),
    .bad_frame_count     (bad_frame_count),
    .overflow_count      (overflow_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int unsigned g, input int unsigned b,
                              input int unsigned o);
    check({tag, "_good"}, 32'(good_frame_count), g);
    check({tag, "_bad"},  32'(bad_frame_count),  b);
    check({tag, "_ovf"},  32'(overflow_count),   o);
  endtask

  initial begin
    reset               = 1'b1;
    status_depth        = '0;
    status_depth_commit = '0;
    status_overflow     = 1'b0;
    status_bad_frame    = 1'b0;
    status_good_frame   = 1'b0;
    pause_ack           = 1'b0;
    force_pause         = 1'b0;
    cnt_clear           = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_pause_req", 32'(pause_req), 1);
    check("rst_paused", 32'(paused), 0);
    check("rst_ack_timeout", 32'(ack_timeout), 0);
    check_counts("rst", 0, 0, 0);
    reset = 1'b0;

    // Threshold ramp: 0..1023 keeps the hold, ack held high meanwhile
    pause_ack = 1'b1;
    for (int unsigned d = 0; d < 1024; d++) begin
      status_depth = DW'(d);
      tick();
      check("ramp_hold", 32'(pause_req), 1);
    end
    check("ramp_paused", 32'(paused), 1);
    check("ramp_no_timeout", 32'(ack_timeout), 0);

    // Exactly START_LEVEL releases one cycle later
    status_depth = DW'(1024);
    pause_ack    = 1'b0;
    tick();
    check("thresh_release", 32'(pause_req), 0);
    check("thresh_paused_drop", 32'(paused), 0);

    // Drain to zero re-pauses
    status_depth = '0;
    pause_ack    = 1'b1;
    tick();
    check("drain_hold", 32'(pause_req), 1);

    // Commit release
    status_depth = DW'(10);
    tick();
    check("commit_zero_hold", 32'(pause_req), 1);
    status_depth_commit = DW'(10);
    pause_ack           = 1'b0;
    tick();
    check("commit_release", 32'(pause_req), 0);
    status_depth        = '0;
    status_depth_commit = '0;
    pause_ack           = 1'b1;
    tick();
    check("commit_drain_hold", 32'(pause_req), 1);

    // Force pause while running
    status_depth = DW'(2000);
    pause_ack    = 1'b0;
    tick();
    check("force_pre_run", 32'(pause_req), 0);
    force_pause = 1'b1;
    pause_ack   = 1'b1;
    tick();
    check("force_hold", 32'(pause_req), 1);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("force_still_hold", 32'(pause_req), 1);
    end
    force_pause = 1'b0;
    pause_ack   = 1'b0;
    tick();
    check("force_drop_release", 32'(pause_req), 0);

    // Ack timeout: 8 unacknowledged hold cycles
    status_depth = '0;
    tick();
    check("to_hold", 32'(pause_req), 1);
    for (int unsigned i = 1; i <= 7; i++) begin
      tick();
    end
    check("to_before", 32'(ack_timeout), 0);
    tick();
    check("to_set", 32'(ack_timeout), 1);
    pause_ack = 1'b1;
    tick();
    check("to_sticky", 32'(ack_timeout), 1);
    check("to_paused", 32'(paused), 1);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("to_cleared", 32'(ack_timeout), 0);

    // Saturating counters: 20 good pulses, 3 overflow pulses alongside
    status_good_frame = 1'b1;
    for (int unsigned i = 1; i <= 20; i++) begin
      status_overflow = (i <= 3);
      tick();
      if (i == 14) check("good_14", 32'(good_frame_count), 14);
      if (i == 15) check("good_15", 32'(good_frame_count), 15);
    end
    status_good_frame = 1'b0;
    status_overflow   = 1'b0;
    check_counts("sat", 15, 0, 3);

    // Clear coincident with a bad-frame pulse
    cnt_clear        = 1'b1;
    status_bad_frame = 1'b1;
    tick();
    cnt_clear        = 1'b0;
    status_bad_frame = 1'b0;
    check_counts("clr_bad", 0, 1, 0);
    check("clr_state_kept", 32'(pause_req), 1);

    // Reset mid-RUN
    status_depth = DW'(2000);
    pause_ack    = 1'b0;
    tick();
    check("mid_run", 32'(pause_req), 0);
    status_good_frame = 1'b1;
    tick();
    status_good_frame = 1'b0;
    check("mid_good", 32'(good_frame_count), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    status_depth = '0;
    check("mid_rst_pause_req", 32'(pause_req), 1);
    check("mid_rst_paused", 32'(paused), 0);
    check_counts("mid_rst", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
